// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bundle: hazard/EX control inputs, instruction-memory handshake and PC observation.
// master is the fetch sequencer, slave is the surrounding pipeline and memory.
interface fetch_sequencer_if;
    logic        stall;
    logic        halt;
    logic        trap;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        flush;
    logic        misaligned_fault;

    modport master (
        input  stall, halt, trap, redirect_valid, redirect_target, imem_ready,
        output imem_req, imem_addr, pc, pc_next, flush, misaligned_fault
    );

    modport slave (
        output stall, halt, trap, redirect_valid, redirect_target, imem_ready,
        input  imem_req, imem_addr, pc, pc_next, flush, misaligned_fault
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC and arbitrates trap, redirect, halt,
// stall and memory back-pressure to choose the next fetch address.
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    logic        imem_req_r;
    logic        flush_s;
    logic        fault_s;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    // Next-state and next-PC arbitration; reset forces the reset vector with no side effects.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        flush_s      = 1'b0;
        fault_s      = 1'b0;
        if (reset) begin
            state_next_s = ST_BOOT;
            pc_next_s    = RESET_VECTOR;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    state_next_s = ST_RUN;
                end
                ST_RUN: begin
                    if (bus.trap) begin
                        pc_next_s = TRAP_VECTOR;
                        flush_s   = 1'b1;
                    end else if (bus.redirect_valid && is_misaligned(bus.redirect_target)) begin
                        pc_next_s = TRAP_VECTOR;
                        flush_s   = 1'b1;
                        fault_s   = 1'b1;
                    end else if (bus.redirect_valid) begin
                        pc_next_s = bus.redirect_target;
                        flush_s   = 1'b1;
                    end else if (bus.halt) begin
                        state_next_s = ST_HALT;
                    end else if (bus.stall || !bus.imem_ready) begin
                        pc_next_s = pc_r;
                    end else begin
                        // Modulo-2^32 increment: wrap past the top of memory is silent.
                        pc_next_s = pc_r + 32'd4;
                    end
                end
                ST_HALT: begin
                    if (bus.trap) begin
                        pc_next_s    = TRAP_VECTOR;
                        flush_s      = 1'b1;
                        state_next_s = ST_RUN;
                    end else begin
                        pc_next_s = pc_r;
                    end
                end
                default: begin
                    state_next_s = ST_BOOT;
                    pc_next_s    = RESET_VECTOR;
                end
            endcase
        end
    end

    // State, PC and fetch-request registers; imem_req is high exactly while in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_BOOT;
            pc_r       <= RESET_VECTOR;
            imem_req_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            pc_r       <= pc_next_s;
            imem_req_r <= (state_next_s == ST_RUN);
        end
    end

    assign bus.pc               = pc_r;
    assign bus.imem_addr        = pc_r;
    assign bus.imem_req         = imem_req_r;
    assign bus.pc_next          = pc_next_s;
    assign bus.flush            = flush_s;
    assign bus.misaligned_fault = fault_s;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: each task drives a scenario and checks
// PC, request and flush behaviour against hand-computed values.
module tb_fetch_sequencer;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fetch_sequencer_if bus();

    fetch_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall           = 1'b0;
        bus.halt            = 1'b0;
        bus.trap            = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0000_0000;
        bus.imem_ready      = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        #1;
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", bus.pc, 32'h0); end
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", bus.imem_req); end
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b expected 0", bus.flush); end
        checks++; if (bus.pc_next !== 32'h0) begin errors++; $display("FAIL reset_pc_next: got %h expected 0", bus.pc_next); end
        reset = 1'b0;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL boot_req: got %b expected 0", bus.imem_req); end
        checks++; if (bus.pc_next !== 32'h0) begin errors++; $display("FAIL boot_pc_next: got %h expected 0", bus.pc_next); end
        tick();
        checks++; if (bus.pc !== 32'h0 || bus.imem_req !== 1'b1) begin errors++; $display("FAIL first_fetch: got pc %h req %b expected pc 0 req 1", bus.pc, bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h expected 0", bus.imem_addr); end
        tick();
        checks++; if (bus.pc !== 32'h4) begin errors++; $display("FAIL run_pc4: got %h expected 4", bus.pc); end
        tick();
        checks++; if (bus.pc !== 32'h8) begin errors++; $display("FAIL run_pc8: got %h expected 8", bus.pc); end
    endtask

    task automatic test_stall();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.pc !== 32'h8 || bus.imem_addr !== 32'h8) begin errors++; $display("FAIL stall_hold: got pc %h addr %h expected 8", bus.pc, bus.imem_addr); end
            tick();
        end
        bus.stall = 1'b0;
        #1;
        checks++; if (bus.pc_next !== 32'hC) begin errors++; $display("FAIL stall_release_next: got %h expected c", bus.pc_next); end
        tick();
        checks++; if (bus.pc !== 32'hC) begin errors++; $display("FAIL stall_release_pc: got %h expected c", bus.pc); end
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.pc !== 32'hC || bus.imem_addr !== 32'hC || bus.imem_req !== 1'b1) begin errors++; $display("FAIL backpressure_hold: got pc %h addr %h req %b expected c c 1", bus.pc, bus.imem_addr, bus.imem_req); end
            tick();
        end
        bus.imem_ready = 1'b1;
        tick();
        checks++; if (bus.pc !== 32'h10) begin errors++; $display("FAIL backpressure_release: got %h expected 10", bus.pc); end
    endtask

    task automatic test_redirect();
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h40;
        bus.stall           = 1'b1;
        #1;
        checks++; if (bus.flush !== 1'b1 || bus.misaligned_fault !== 1'b0) begin errors++; $display("FAIL redirect_flush: got flush %b fault %b expected 1 0", bus.flush, bus.misaligned_fault); end
        checks++; if (bus.pc_next !== 32'h40) begin errors++; $display("FAIL redirect_next: got %h expected 40", bus.pc_next); end
        tick();
        idle_inputs();
        #1;
        checks++; if (bus.pc !== 32'h40 || bus.flush !== 1'b0) begin errors++; $display("FAIL redirect_pc: got pc %h flush %b expected 40 0", bus.pc, bus.flush); end
    endtask

    task automatic test_misaligned();
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h42;
        #1;
        checks++; if (bus.misaligned_fault !== 1'b1 || bus.flush !== 1'b1) begin errors++; $display("FAIL misaligned_flags: got fault %b flush %b expected 1 1", bus.misaligned_fault, bus.flush); end
        checks++; if (bus.pc_next !== 32'h100) begin errors++; $display("FAIL misaligned_next: got %h expected 100", bus.pc_next); end
        tick();
        idle_inputs();
        #1;
        checks++; if (bus.pc !== 32'h100 || bus.misaligned_fault !== 1'b0) begin errors++; $display("FAIL misaligned_pc: got pc %h fault %b expected 100 0", bus.pc, bus.misaligned_fault); end
        tick();
        bus.trap            = 1'b1;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h42;
        #1;
        checks++; if (bus.pc_next !== 32'h100 || bus.flush !== 1'b1 || bus.misaligned_fault !== 1'b0) begin errors++; $display("FAIL trap_wins: got next %h flush %b fault %b expected 100 1 0", bus.pc_next, bus.flush, bus.misaligned_fault); end
        tick();
        idle_inputs();
        #1;
        checks++; if (bus.pc !== 32'h100) begin errors++; $display("FAIL trap_pc: got %h expected 100", bus.pc); end
    endtask

    task automatic test_back_to_back();
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h80;
        #1;
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL b2b_flush1: got %b expected 1", bus.flush); end
        tick();
        bus.redirect_target = 32'h200;
        #1;
        checks++; if (bus.pc !== 32'h80 || bus.flush !== 1'b1) begin errors++; $display("FAIL b2b_second: got pc %h flush %b expected 80 1", bus.pc, bus.flush); end
        tick();
        idle_inputs();
        #1;
        checks++; if (bus.pc !== 32'h200) begin errors++; $display("FAIL b2b_pc: got %h expected 200", bus.pc); end
    endtask

    task automatic test_halt();
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h20;
        tick();
        idle_inputs();
        bus.halt = 1'b1;
        #1;
        checks++; if (bus.pc !== 32'h20 || bus.pc_next !== 32'h20 || bus.flush !== 1'b0) begin errors++; $display("FAIL halt_enter: got pc %h next %h flush %b expected 20 20 0", bus.pc, bus.pc_next, bus.flush); end
        tick();
        bus.halt            = 1'b0;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h42;
        bus.stall           = 1'b1;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL halt_req: got %b expected 0", bus.imem_req); end
        checks++; if (bus.flush !== 1'b0 || bus.misaligned_fault !== 1'b0 || bus.pc_next !== 32'h20) begin errors++; $display("FAIL halt_ignore: got flush %b fault %b next %h expected 0 0 20", bus.flush, bus.misaligned_fault, bus.pc_next); end
        tick();
        checks++; if (bus.pc !== 32'h20 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL halt_hold: got pc %h req %b expected 20 0", bus.pc, bus.imem_req); end
        idle_inputs();
        bus.trap = 1'b1;
        #1;
        checks++; if (bus.flush !== 1'b1 || bus.pc_next !== 32'h100) begin errors++; $display("FAIL halt_trap: got flush %b next %h expected 1 100", bus.flush, bus.pc_next); end
        tick();
        bus.trap = 1'b0;
        #1;
        checks++; if (bus.pc !== 32'h100 || bus.imem_req !== 1'b1) begin errors++; $display("FAIL halt_resume: got pc %h req %b expected 100 1", bus.pc, bus.imem_req); end
        tick();
        checks++; if (bus.pc !== 32'h104) begin errors++; $display("FAIL halt_run_on: got %h expected 104", bus.pc); end
    endtask

    task automatic test_wrap_and_reset();
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'hFFFF_FFFC;
        tick();
        idle_inputs();
        #1;
        checks++; if (bus.pc !== 32'hFFFF_FFFC || bus.pc_next !== 32'h0 || bus.misaligned_fault !== 1'b0) begin errors++; $display("FAIL wrap_next: got pc %h next %h fault %b expected fffffffc 0 0", bus.pc, bus.pc_next, bus.misaligned_fault); end
        tick();
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected 0", bus.pc); end
        tick();
        bus.stall           = 1'b1;
        tick();
        reset               = 1'b1;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h40;
        #1;
        checks++; if (bus.flush !== 1'b0 || bus.pc_next !== 32'h0) begin errors++; $display("FAIL reset_override: got flush %b next %h expected 0 0", bus.flush, bus.pc_next); end
        tick();
        checks++; if (bus.pc !== 32'h0 || bus.imem_req !== 1'b0 || bus.flush !== 1'b0) begin errors++; $display("FAIL reset_mid_stall: got pc %h req %b flush %b expected 0 0 0", bus.pc, bus.imem_req, bus.flush); end
        reset = 1'b0;
        idle_inputs();
        tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.pc !== 32'h0) begin errors++; $display("FAIL reset_restart: got req %b pc %h expected 1 0", bus.imem_req, bus.pc); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle_inputs();
        test_reset();
        test_stall();
        test_redirect();
        test_misaligned();
        test_back_to_back();
        test_halt();
        test_wrap_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
